// File: rtl/adc_proc_pkg.sv
// Shared widths, stage bundles and saturation helper
// for the multi-channel ADC averaging/scaling path.
package adc_proc_pkg;

   localparam int DEF_DATA_W  = 16;
   localparam int DEF_SCALE_W = 20;
   localparam int DEF_PROD_W  = DEF_DATA_W + DEF_SCALE_W;
   localparam int CH_W        = 3;

   typedef struct packed {
      logic                  valid;
      logic [CH_W-1:0]       ch;
      logic [DEF_DATA_W-1:0] val;
   } s12_t;

   typedef struct packed {
      logic                  valid;
      logic [CH_W-1:0]       ch;
      logic [DEF_DATA_W-1:0] ave;
      logic [DEF_PROD_W-1:0] prod;
   } s23_t;

   // v is signed two's complement, one bit wider than the product
   function automatic logic [DEF_DATA_W-1:0] sat(
      input logic [DEF_PROD_W:0] v
   );
      if (v[DEF_PROD_W])
         return '0;
      else if (|v[DEF_PROD_W-1:DEF_DATA_W])
         return '1;
      else
         return v[DEF_DATA_W-1:0];
   endfunction

endpackage

// File: rtl/adc_multi_proc_if.sv
// Sample/config/result bundle between ADC front-ends and adc_multi_proc.
// min_out/max_out exist only with ADC_MULTI_PROC_PEAK_EN.
interface adc_multi_proc_if
   import adc_proc_pkg::*;
#(
   parameter int N_CH    = 3,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int SCALE_W = DEF_SCALE_W
) ();

   logic [N_CH-1:0]         ready;
   logic [N_CH*DATA_W-1:0]  data;
   logic [N_CH*SCALE_W-1:0] scale;
   logic [N_CH*DATA_W-1:0]  offset;
   logic [N_CH-1:0]         clear;
   logic [N_CH*DATA_W-1:0]  ave_out;
   logic [N_CH*DATA_W-1:0]  scaled_out;
   logic [N_CH-1:0]         out_valid;
   logic [N_CH-1:0]         overrun;
`ifdef ADC_MULTI_PROC_PEAK_EN
   logic [N_CH*DATA_W-1:0]  min_out;
   logic [N_CH*DATA_W-1:0]  max_out;

   modport master (
      output ready, data, scale, offset, clear,
      input  ave_out, scaled_out, out_valid, overrun,
      input  min_out, max_out
   );

   modport slave (
      input  ready, data, scale, offset, clear,
      output ave_out, scaled_out, out_valid, overrun,
      output min_out, max_out
   );
`else
   modport master (
      output ready, data, scale, offset, clear,
      input  ave_out, scaled_out, out_valid, overrun
   );

   modport slave (
      input  ready, data, scale, offset, clear,
      output ave_out, scaled_out, out_valid, overrun
   );
`endif

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus index; the pointer
// moves to grant+1 on advance.
module rr_arbiter #(
   parameter int N  = 3,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [N-1:0]  req,
   input  logic          advance,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx
);

   logic [IW-1:0] r_ptr;
   logic          w_found;
   int            w_j;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      w_found   = 1'b0;
      w_j       = 0;
      for (int i = 0; i < N; i++) begin
         w_j = int'(r_ptr) + i;
         if (w_j >= N)
            w_j = w_j - N;
         if (!w_found && req[w_j]) begin
            w_found    = 1'b1;
            grant[w_j] = 1'b1;
            grant_idx  = IW'(w_j);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         r_ptr <= '0;
      else if (advance && w_found)
         r_ptr <= (grant_idx == IW'(N - 1)) ? '0
                : grant_idx + IW'(1);
   end

endmodule

// File: rtl/adc_multi_proc.sv
// Shared capture/arbitrate/average/scale datapath for N_CH ADC streams.
// Optional min/max tracking enabled by ADC_MULTI_PROC_PEAK_EN.
module adc_multi_proc
   import adc_proc_pkg::*;
#(
   parameter int N_CH     = 3,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int AVG_LOG2 = 4,
   parameter int SCALE_W  = DEF_SCALE_W,
   parameter int SHIFT    = 16
) (
   input logic           clk,
   input logic           reset,
   adc_multi_proc_if.slave bus
);

   localparam int ACC_W  = DATA_W + AVG_LOG2;
   localparam int CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam int PROD_W = DATA_W + SCALE_W;
   localparam int IW     = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic [DATA_W-1:0] r_hold [N_CH];
   logic [N_CH-1:0]   r_pend;
   logic [N_CH-1:0]   r_ovr;
   logic [ACC_W-1:0]  r_acc  [N_CH];
   logic [CNT_W-1:0]  r_cnt  [N_CH];
   s12_t              r_s1;
   s12_t              r_s2;
   logic [DATA_W-1:0] r_ave  [N_CH];
   logic [DATA_W-1:0] r_scl  [N_CH];
   logic [N_CH-1:0]   r_vld;

   logic [N_CH-1:0]    w_req;
   logic [N_CH-1:0]    w_grant;
   logic [IW-1:0]      w_gidx;
   logic [DATA_W-1:0]  w_gval;
   logic [ACC_W-1:0]   w_sel_acc;
   logic [CNT_W-1:0]   w_sel_cnt;
   logic               w_s1_clr;
   logic               w_s1_ok;
   logic               w_last;
   logic [ACC_W-1:0]   w_sum;
   logic [SCALE_W-1:0] w_scale;
   logic [DATA_W-1:0]  w_off;
   s23_t               w_s23;
   logic [PROD_W:0]    w_diff;
   logic [DATA_W-1:0]  w_scl;
   logic [N_CH-1:0]    w_hit;

   // a channel being cleared must not be issued this cycle
   assign w_req = r_pend & ~bus.clear;

   rr_arbiter #(.N(N_CH)) u_arb (
      .clk       (clk),
      .reset     (reset),
      .req       (w_req),
      .advance   (|w_req),
      .grant     (w_grant),
      .grant_idx (w_gidx)
   );

   always_comb begin
      w_gval = '0;
      for (int c = 0; c < N_CH; c++)
         if (w_grant[c])
            w_gval = r_hold[c];
   end

   always_ff @(posedge clk) begin
      for (int c = 0; c < N_CH; c++) begin
         if (reset) begin
            r_hold[c] <= '0;
            r_pend[c] <= 1'b0;
            r_ovr[c]  <= 1'b0;
         end else if (bus.clear[c]) begin
            r_pend[c] <= 1'b0;
            r_ovr[c]  <= 1'b0;
         end else if (bus.ready[c]) begin
            r_hold[c] <= bus.data[c*DATA_W +: DATA_W];
            r_pend[c] <= 1'b1;
            if (r_pend[c] && !w_grant[c])
               r_ovr[c] <= 1'b1;
         end else if (w_grant[c]) begin
            r_pend[c] <= 1'b0;
         end
      end
   end

   always_comb begin
      w_sel_acc = '0;
      w_sel_cnt = '0;
      w_s1_clr  = 1'b0;
      for (int c = 0; c < N_CH; c++)
         if (r_s1.ch == CH_W'(c)) begin
            w_sel_acc = r_acc[c];
            w_sel_cnt = r_cnt[c];
            w_s1_clr  = bus.clear[c];
         end
      w_sum   = w_sel_acc + ACC_W'(r_s1.val);
      w_last  = (w_sel_cnt == CNT_W'((1 << AVG_LOG2) - 1));
      w_s1_ok = r_s1.valid && !w_s1_clr;
   end

   always_ff @(posedge clk) begin
      for (int c = 0; c < N_CH; c++) begin
         if (reset || bus.clear[c]) begin
            r_acc[c] <= '0;
            r_cnt[c] <= '0;
         end else if (w_s1_ok && r_s1.ch == CH_W'(c)) begin
            if (w_last) begin
               r_acc[c] <= '0;
               r_cnt[c] <= '0;
            end else begin
               r_acc[c] <= w_sum;
               r_cnt[c] <= r_cnt[c] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1 <= '0;
         r_s2 <= '0;
      end else begin
         r_s1.valid <= |w_grant;
         r_s1.ch    <= CH_W'(w_gidx);
         r_s1.val   <= w_gval;
         r_s2.valid <= w_s1_ok && w_last;
         r_s2.ch    <= r_s1.ch;
         r_s2.val   <= DATA_W'(w_sum >> AVG_LOG2);
      end
   end

   // multiply and scale share one cycle so outputs land at ready+4
   always_comb begin
      w_scale = '0;
      w_off   = '0;
      w_hit   = '0;
      for (int c = 0; c < N_CH; c++)
         if (r_s2.ch == CH_W'(c)) begin
            w_scale  = bus.scale[c*SCALE_W +: SCALE_W];
            w_off    = bus.offset[c*DATA_W +: DATA_W];
            w_hit[c] = r_s2.valid;
         end
      w_s23.valid = r_s2.valid;
      w_s23.ch    = r_s2.ch;
      w_s23.ave   = r_s2.val;
      w_s23.prod  = PROD_W'(r_s2.val) * PROD_W'(w_scale);
      w_diff = {1'b0, w_s23.prod >> SHIFT}
             - {{(PROD_W + 1 - DATA_W){1'b0}}, w_off};
      w_scl  = sat(w_diff);
   end

   always_ff @(posedge clk) begin
      for (int c = 0; c < N_CH; c++) begin
         if (reset) begin
            r_vld[c] <= 1'b0;
            r_ave[c] <= '0;
            r_scl[c] <= '0;
         end else begin
            r_vld[c] <= w_hit[c];
            if (w_hit[c]) begin
               r_ave[c] <= w_s23.ave;
               r_scl[c] <= w_scl;
            end
         end
      end
   end

   assign bus.out_valid = r_vld;
   assign bus.overrun   = r_ovr;

   for (genvar g = 0; g < N_CH; g++) begin : g_out
      assign bus.ave_out[g*DATA_W +: DATA_W]    = r_ave[g];
      assign bus.scaled_out[g*DATA_W +: DATA_W] = r_scl[g];
   end

`ifdef ADC_MULTI_PROC_PEAK_EN
   logic [DATA_W-1:0] r_min [N_CH];
   logic [DATA_W-1:0] r_max [N_CH];

   // all-ones/zero seeds make the first result load both peaks
   always_ff @(posedge clk) begin
      for (int c = 0; c < N_CH; c++) begin
         if (reset || bus.clear[c]) begin
            r_min[c] <= '1;
            r_max[c] <= '0;
         end else if (w_hit[c]) begin
            if (w_scl < r_min[c])
               r_min[c] <= w_scl;
            if (w_scl > r_max[c])
               r_max[c] <= w_scl;
         end
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_peak
      assign bus.min_out[g*DATA_W +: DATA_W] = r_min[g];
      assign bus.max_out[g*DATA_W +: DATA_W] = r_max[g];
   end
`endif

endmodule

// File: tb/tb_adc_multi_proc.sv
// Directed scoreboard bench for adc_multi_proc (N_CH=3, AVG_LOG2=2).
module tb_adc_multi_proc;

   localparam int NC = 3;

   typedef struct {
      logic [15:0] ave;
      logic [15:0] scl;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   exp_t   q [NC][$];
   longint m_sum [NC];
   int     m_cnt [NC];
   longint m_scale [NC];
   longint m_off [NC];

   adc_multi_proc_if #(.N_CH(NC), .DATA_W(16), .SCALE_W(20)) bus ();

   adc_multi_proc #(
      .N_CH(NC), .DATA_W(16), .AVG_LOG2(2),
      .SCALE_W(20), .SHIFT(16)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] exp_scl(longint ave, longint sc,
                                           longint off);
      longint v;
      v = ((ave * sc) >> 16) - off;
      if (v < 0) return 16'h0;
      if (v > 65535) return 16'hFFFF;
      return v[15:0];
   endfunction

   always @(negedge clk) begin
      for (int c = 0; c < NC; c++) begin
         if (bus.out_valid[c]) begin
            chk($sformatf("valid_expected_ch%0d", c),
                64'(q[c].size() != 0), 64'd1);
            if (q[c].size() != 0) begin
               exp_t e;
               e = q[c].pop_front();
               chk($sformatf("ave_ch%0d", c),
                   64'(bus.ave_out[c*16 +: 16]), 64'(e.ave));
               chk($sformatf("scaled_ch%0d", c),
                   64'(bus.scaled_out[c*16 +: 16]), 64'(e.scl));
               chk($sformatf("valid_cycle_ch%0d", c),
                   64'(cyc), 64'(e.cyc));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic model_clr(input int ch);
      m_sum[ch] = 0;
      m_cnt[ch] = 0;
   endtask

   task automatic model_add(input int ch, input longint v, input int ecyc);
      exp_t e;
      m_sum[ch] += v;
      m_cnt[ch]++;
      if (m_cnt[ch] == 4) begin
         e.ave = 16'(m_sum[ch] / 4);
         e.scl = exp_scl(m_sum[ch] / 4, m_scale[ch], m_off[ch]);
         e.cyc = ecyc;
         q[ch].push_back(e);
         model_clr(ch);
      end
   endtask

   task automatic set_cfg(input int ch, input longint sc, input longint off);
      m_scale[ch] = sc;
      m_off[ch]   = off;
      bus.scale[ch*20 +: 20]  = 20'(sc);
      bus.offset[ch*16 +: 16] = 16'(off);
   endtask

   task automatic samp(input int ch, input logic [15:0] v);
      bus.ready = 3'(1 << ch);
      bus.data[ch*16 +: 16] = v;
      model_add(ch, longint'(v), cyc + 4);
      tick();
      bus.ready = '0;
   endtask

   task automatic samp_block(input int ch, input logic [15:0] v);
      for (int k = 0; k < 4; k++) begin
         samp(ch, v);
         idle(9);
      end
   endtask

   task automatic do_clear(input logic [NC-1:0] m);
      bus.clear = m;
      for (int c = 0; c < NC; c++)
         if (m[c]) model_clr(c);
      tick();
      bus.clear = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle(3);
      reset = 1'b0;
      for (int c = 0; c < NC; c++) model_clr(c);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ave"}, 64'(bus.ave_out), 64'd0);
      chk({tag, "_scaled"}, 64'(bus.scaled_out), 64'd0);
      chk({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
      chk({tag, "_overrun"}, 64'(bus.overrun), 64'd0);
   endtask

   initial begin
      bus.ready  = '0;
      bus.data   = '0;
      bus.clear  = '0;
      bus.scale  = '0;
      bus.offset = '0;
      for (int c = 0; c < NC; c++) begin
         set_cfg(c, 65536, 0);
         model_clr(c);
      end
      do_reset();
      chk_zero("reset");

      // single channel block, one sample per 10 cycles
      samp(0, 100); idle(9);
      samp(0, 200); idle(9);
      samp(0, 300); idle(9);
      samp(0, 400); idle(9);

      // three-way contention, pointer restarted at ch0
      do_reset();
      for (int k = 0; k < 4; k++) begin
         bus.ready = 3'b111;
         bus.data  = {16'd8, 16'd8, 16'd8};
         model_add(0, 8, cyc + 4);
         model_add(1, 8, cyc + 5);
         model_add(2, 8, cyc + 6);
         tick();
         bus.ready = '0;
         idle(9);
      end

      // ch2 overwritten before issue
      bus.ready = 3'b111;
      bus.data  = {16'd0, 16'd2, 16'd1};
      model_add(0, 1, 0);
      model_add(1, 2, 0);
      tick();
      bus.ready = 3'b100;
      bus.data[47:32] = 16'd55;
      model_add(2, 55, 0);
      tick();
      bus.ready = '0;
      idle(4);
      chk("overrun_set", 64'(bus.overrun), 64'b100);
      idle(5);
      for (int k = 0; k < 3; k++) begin
         samp(2, 55);
         idle(9);
      end
      do_clear(3'b111);
      chk("overrun_cleared", 64'(bus.overrun), 64'd0);
      chk("ave_kept_on_clear", 64'(bus.ave_out[47:32]), 64'd55);

      // saturation at both ends
      set_cfg(1, 65536, 300);
      samp_block(1, 250);
      set_cfg(2, (1 << 19) - 1, 0);
      samp_block(2, 16'hFFFF);
      set_cfg(1, 65536, 0);
      set_cfg(2, 65536, 0);

      // reset mid-block flushes in-flight work
      samp(0, 77); idle(9);
      samp(0, 77);
      do_reset();
      chk_zero("midreset");
      samp_block(0, 10);

`ifdef ADC_MULTI_PROC_PEAK_EN
      do_clear(3'b001);
      chk("min_after_clear0", 64'(bus.min_out[15:0]), 64'hFFFF);
      samp_block(0, 50);
      samp_block(0, 20);
      samp_block(0, 90);
      chk("min_peak", 64'(bus.min_out[15:0]), 64'd20);
      chk("max_peak", 64'(bus.max_out[15:0]), 64'd90);
      do_clear(3'b001);
      chk("min_after_clear", 64'(bus.min_out[15:0]), 64'hFFFF);
      chk("max_after_clear", 64'(bus.max_out[15:0]), 64'd0);
`endif

      idle(10);
      for (int c = 0; c < NC; c++)
         chk($sformatf("drained_ch%0d", c), 64'(q[c].size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
